// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU front end.
// Holds the fetch sequencer state encoding and the opcode/field constants.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH0   = 4'd0,
        S_FETCH1   = 4'd1,
        S_DATA     = 4'd2,
        S_ADDR     = 4'd3,
        S_PTR_LO   = 4'd4,
        S_PTR_HI   = 4'd5,
        S_OPER     = 4'd6,
        S_WRITE    = 4'd7,
        S_EXEC_CHK = 4'd8,
        S_EXEC     = 4'd9,
        S_HALTED   = 4'd10
    } state_t;

    localparam logic [7:0]  OP_NOP       = 8'h00;
    localparam logic [7:0]  OP_HALT      = 8'h01;
    localparam logic [7:0]  OP_LOAD_IND  = 8'h44;
    localparam logic [15:0] ONE_ARG_MASK = 16'hF800;
    localparam logic [15:0] SRC_MASK     = 16'h0700;

    // Opcodes with bit 7 set carry an argument byte.
    function automatic logic has_arg(input logic [7:0] opcode);
        return opcode[7];
    endfunction

endpackage

// File: rtl/bus_port.sv
// Byte-wide memory bus port: presents the sequencer's request on the bus,
// flags transfer completion and keeps the last read byte.
module bus_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [7:0]  rdata_q
);

    // Request is gated by reset so an in-flight access is dropped at once.
    assign mem_req   = req & ~rst;
    assign mem_we    = req & we & ~rst;
    assign mem_addr  = addr;
    assign mem_wdata = mem_we ? wdata : 8'h00;
    assign done      = mem_req & mem_ack;
    assign rdata     = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= 8'h00;
        else if (done)
            rdata_q <= mem_rdata;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/operand/store sequencer for the 16-bit CPU.
// Owns the PC, walks each instruction over the byte bus and strobes execute.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        dec_en,
    output logic [15:0] inst,
    output logic [7:0]  data,
    output logic [7:0]  operand,
    input  logic [1:0]  dec_bytes,
    input  logic        dec_source_imm,
    input  logic        dec_source_ram,
    input  logic        dec_source_indirect,
    input  logic        dec_relative_stack,
    input  logic        dec_store,
    input  logic        dec_branch,
    input  logic        dec_halt,
    input  logic [15:0] dec_rhs,
    input  logic [15:0] dp,
    input  logic [15:0] sp,
    input  logic [7:0]  store_data,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    input  logic        resume,
    output logic [15:0] pc,
    output logic        exec_strobe,
    output logic        halted
);

    state_t      state, state_next;
    logic [15:0] ea;
    logic        bus_req, bus_we, done;
    logic [15:0] bus_addr;
    logic [7:0]  rdata, rdata_q;

    // Instruction length is implied by opcode bit 7 here.
    logic unused_dec_bytes;
    assign unused_dec_bytes = ^dec_bytes;

    bus_port u_bus (
        .clk       (clk),
        .rst       (rst),
        .req       (bus_req),
        .we        (bus_we),
        .addr      (bus_addr),
        .wdata     (store_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .rdata     (rdata),
        .rdata_q   (rdata_q)
    );

    always_comb begin
        state_next  = state;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = pc;
        dec_en      = (state != S_FETCH0) && (state != S_HALTED);
        exec_strobe = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH0: begin
                bus_req = 1'b1;
                if (done) state_next = has_arg(rdata) ? S_FETCH1 : S_EXEC_CHK;
            end
            S_FETCH1: begin
                bus_req = 1'b1;
                if (done) state_next = (dec_source_imm && inst[9]) ? S_DATA : S_ADDR;
            end
            S_DATA: begin
                bus_req = 1'b1;
                if (done) state_next = S_EXEC;
            end
            S_ADDR: begin
                if (dec_source_indirect)              state_next = S_PTR_LO;
                else if (dec_source_ram && dec_store) state_next = S_WRITE;
                else if (dec_source_ram)              state_next = S_OPER;
                else                                  state_next = S_EXEC;
            end
            S_PTR_LO: begin
                bus_req  = 1'b1;
                bus_addr = ea;
                if (done) state_next = S_PTR_HI;
            end
            S_PTR_HI: begin
                bus_req  = 1'b1;
                bus_addr = ea + 16'd1;
                if (done) state_next = dec_store ? S_WRITE : S_OPER;
            end
            S_OPER: begin
                bus_req  = 1'b1;
                bus_addr = ea;
                if (done) state_next = S_EXEC;
            end
            S_WRITE: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = ea;
                if (done) state_next = S_EXEC;
            end
            S_EXEC_CHK: state_next = S_EXEC;
            S_EXEC: begin
                exec_strobe = 1'b1;
                state_next  = dec_halt ? S_HALTED : S_FETCH0;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (resume) state_next = S_FETCH0;
            end
            default: state_next = S_FETCH0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH0;
            pc      <= RESET_PC;
            inst    <= 16'h0000;
            data    <= 8'h00;
            operand <= 8'h00;
            ea      <= 16'h0000;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH0: if (done) begin
                    inst <= {rdata, 8'h00};
                    pc   <= pc + 16'd1;
                end
                S_FETCH1: if (done) begin
                    inst[7:0] <= rdata;
                    pc        <= pc + 16'd1;
                end
                S_DATA: if (done) begin
                    data <= rdata;
                    pc   <= pc + 16'd1;
                end
                S_ADDR:   ea <= (dec_relative_stack ? sp : dp) + {8'h00, inst[7:0]};
                // Pointer low byte was kept by the bus port on the previous read.
                S_PTR_HI: if (done) ea <= {rdata, rdata_q};
                S_OPER:   if (done) operand <= rdata;
                // pc already points past the instruction, so branches are relative to it.
                S_EXEC: begin
                    if (pc_load)         pc <= pc_load_val;
                    else if (dec_branch) pc <= pc + dec_rhs;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte memory with programmable ack delay
// and a small opcode decoder model driven from the instruction register.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        dec_en;
    logic [15:0] inst;
    logic [7:0]  data, operand;
    logic [1:0]  dec_bytes;
    logic        dec_source_imm, dec_source_ram, dec_source_indirect, dec_relative_stack;
    logic        dec_store, dec_branch, dec_halt;
    logic [15:0] dec_rhs;
    logic [15:0] dp = 16'h0000, sp = 16'h0000;
    logic [7:0]  store_data = 8'h00;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    logic        resume = 1'b0;
    logic [15:0] pc;
    logic        exec_strobe, halted;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [65536];
    logic [3:0]  wait_cnt = 4'd0;
    logic [3:0]  ack_delay = 4'd0;
    logic [15:0] log_addr [$];
    logic        log_we [$];
    logic [7:0]  log_wd [$];

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dec_en(dec_en), .inst(inst), .data(data), .operand(operand),
        .dec_bytes(dec_bytes), .dec_source_imm(dec_source_imm), .dec_source_ram(dec_source_ram),
        .dec_source_indirect(dec_source_indirect), .dec_relative_stack(dec_relative_stack),
        .dec_store(dec_store), .dec_branch(dec_branch), .dec_halt(dec_halt), .dec_rhs(dec_rhs),
        .dp(dp), .sp(sp), .store_data(store_data),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .resume(resume),
        .pc(pc), .exec_strobe(exec_strobe), .halted(halted)
    );

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (wait_cnt == ack_delay);

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 4'd1;
        else                     wait_cnt <= 4'd0;
        if (mem_req && mem_ack) begin
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_wd.push_back(mem_wdata);
        end
    end

    // Decoder model for the opcodes this bench uses.
    always_comb begin
        dec_bytes           = inst[15] ? 2'd2 : 2'd1;
        dec_source_imm      = 1'b0;
        dec_source_ram      = 1'b0;
        dec_source_indirect = 1'b0;
        dec_relative_stack  = 1'b0;
        dec_store           = 1'b0;
        dec_branch          = 1'b0;
        dec_halt            = 1'b0;
        dec_rhs             = 16'h0000;
        case (inst[15:8])
            8'h01: dec_halt = 1'b1;
            8'h82: dec_source_imm = 1'b1;
            8'h84: dec_source_ram = 1'b1;
            8'h86: dec_source_indirect = 1'b1;
            8'h8A: begin
                dec_source_indirect = 1'b1;
                dec_store           = 1'b1;
                dec_relative_stack  = 1'b1;
            end
            8'hC7: begin
                dec_branch = 1'b1;
                dec_rhs    = {{8{inst[7]}}, inst[7:0]};
            end
            default: ;
        endcase
    end

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        ack_delay = 4'd0; dp = 16'h0000; sp = 16'h0000; store_data = 8'h00;
        pc_load = 1'b0; pc_load_val = 16'h0000; resume = 1'b0;
        #1;
    endtask

    task automatic release_reset(output int base);
        @(negedge clk);
        @(negedge clk);
        base = log_addr.size();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_exec(input logic [15:0] watch, output int hold);
        bit seen = 1'b0;
        hold = 0;
        for (int i = 0; i < 100; i++) begin
            if (!seen) begin
                @(negedge clk);
                if (mem_req && mem_addr == watch) hold++;
                if (exec_strobe) seen = 1'b1;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL exec_timeout: exec_strobe never seen within 100 cycles");
        end
    endtask

    task automatic test_reset();
        int base;
        apply_reset();
        checks++;
        if ({mem_req, mem_we, dec_en, exec_strobe, halted} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got req/we/en/strobe/halt=%b want 00000",
                     {mem_req, mem_we, dec_en, exec_strobe, halted});
        end
        checks++;
        if (pc !== 16'h0000 || inst !== 16'h0000) begin
            failures++;
            $display("FAIL reset_regs: pc=%h inst=%h want 0000 0000", pc, inst);
        end
        checks++;
        if (data !== 8'h00 || operand !== 8'h00 || mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: data=%h operand=%h wdata=%h want 00", data, operand, mem_wdata);
        end
        release_reset(base);
    endtask

    task automatic test_nop();
        int base, hold;
        apply_reset();
        release_reset(base);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || mem_we !== 1'b0 || dec_en !== 1'b0) begin
            failures++;
            $display("FAIL nop_fetch: req=%b addr=%h we=%b en=%b want 1 0000 0 0",
                     mem_req, mem_addr, mem_we, dec_en);
        end
        @(negedge clk);
        checks++;
        if (exec_strobe !== 1'b0 || dec_en !== 1'b1) begin
            failures++;
            $display("FAIL nop_chk: strobe=%b en=%b want 0 1", exec_strobe, dec_en);
        end
        @(negedge clk);
        checks++;
        if (exec_strobe !== 1'b1) begin
            failures++;
            $display("FAIL nop_exec: strobe=%b want 1", exec_strobe);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || pc !== 16'h0001 || exec_strobe !== 1'b0) begin
            failures++;
            $display("FAIL nop_next: req=%b addr=%h pc=%h strobe=%b want 1 0001 0001 0",
                     mem_req, mem_addr, pc, exec_strobe);
        end
        hold = 0;
    endtask

    task automatic test_two_byte();
        int base, hold;
        apply_reset();
        mem[0] = 8'h80; mem[1] = 8'h2A;
        release_reset(base);
        wait_exec(16'hFFFF, hold);
        checks++;
        if (inst !== 16'h802A || pc !== 16'h0002) begin
            failures++;
            $display("FAIL two_byte: inst=%h pc=%h want 802A 0002", inst, pc);
        end
        checks++;
        if (log_addr.size() != base + 2 || log_addr[base] !== 16'h0000 || log_addr[base+1] !== 16'h0001) begin
            failures++;
            $display("FAIL two_byte_bus: transfers=%0d want 2 at 0000,0001", log_addr.size() - base);
        end
    endtask

    task automatic test_imm();
        int base, hold;
        apply_reset();
        mem[0] = 8'h82; mem[1] = 8'h00; mem[2] = 8'h55;
        release_reset(base);
        wait_exec(16'hFFFF, hold);
        checks++;
        if (data !== 8'h55 || pc !== 16'h0003 || inst !== 16'h8200) begin
            failures++;
            $display("FAIL imm: data=%h pc=%h inst=%h want 55 0003 8200", data, pc, inst);
        end
        checks++;
        if (log_addr.size() != base + 3 || log_addr[base+2] !== 16'h0002) begin
            failures++;
            $display("FAIL imm_bus: transfers=%0d want 3 ending at 0002", log_addr.size() - base);
        end
    endtask

    task automatic test_ram_wait();
        int base, hold;
        apply_reset();
        mem[0] = 8'h84; mem[1] = 8'h10; mem[16'h0110] = 8'h77;
        dp = 16'h0100; ack_delay = 4'd3;
        release_reset(base);
        wait_exec(16'h0110, hold);
        checks++;
        if (hold != 4) begin
            failures++;
            $display("FAIL ram_hold: cycles at 0110=%0d want 4", hold);
        end
        checks++;
        if (operand !== 8'h77 || pc !== 16'h0002) begin
            failures++;
            $display("FAIL ram_operand: operand=%h pc=%h want 77 0002", operand, pc);
        end
        checks++;
        if (log_addr.size() != base + 3 || log_addr[base+2] !== 16'h0110) begin
            failures++;
            $display("FAIL ram_bus: transfers=%0d want 3 ending at 0110", log_addr.size() - base);
        end
    endtask

    task automatic test_indirect();
        int base, hold;
        apply_reset();
        mem[0] = 8'h86; mem[1] = 8'h10;
        mem[16'h0310] = 8'h00; mem[16'h0311] = 8'h05; mem[16'h0500] = 8'h99;
        dp = 16'h0300;
        release_reset(base);
        wait_exec(16'hFFFF, hold);
        checks++;
        if (operand !== 8'h99) begin
            failures++;
            $display("FAIL ind_operand: operand=%h want 99", operand);
        end
        checks++;
        if (log_addr.size() != base + 5 || log_addr[base+2] !== 16'h0310 ||
            log_addr[base+3] !== 16'h0311 || log_addr[base+4] !== 16'h0500) begin
            failures++;
            $display("FAIL ind_bus: transfers=%0d want 5 via 0310,0311,0500", log_addr.size() - base);
        end
    endtask

    task automatic test_store_wrap();
        int base, hold;
        apply_reset();
        mem[0] = 8'h8A; mem[1] = 8'hFF; mem[16'hFFFF] = 8'h34;
        sp = 16'hFF00; dp = 16'h0000; store_data = 8'h5A;
        release_reset(base);
        wait_exec(16'hFFFF, hold);
        checks++;
        if (log_addr.size() != base + 5 || log_addr[base+2] !== 16'hFFFF ||
            log_addr[base+3] !== 16'h0000 || log_addr[base+4] !== 16'h8A34) begin
            failures++;
            $display("FAIL store_bus: transfers=%0d want 5 via FFFF,0000,8A34", log_addr.size() - base);
        end else begin
            checks++;
            if (log_we[base+4] !== 1'b1 || log_wd[base+4] !== 8'h5A || log_we[base+3] !== 1'b0) begin
                failures++;
                $display("FAIL store_write: we=%b wdata=%h want 1 5A", log_we[base+4], log_wd[base+4]);
            end
        end
        checks++;
        if (mem_we !== 1'b0 || pc !== 16'h0002) begin
            failures++;
            $display("FAIL store_exec: we=%b pc=%h want 0 0002", mem_we, pc);
        end
    endtask

    task automatic test_branch();
        int base, hold;
        apply_reset();
        mem[0] = 8'hC7; mem[1] = 8'hFE;
        release_reset(base);
        wait_exec(16'hFFFF, hold);
        checks++;
        if (pc !== 16'h0002) begin
            failures++;
            $display("FAIL br_pre: pc=%h want 0002", pc);
        end
        @(negedge clk);
        checks++;
        if (pc !== 16'h0000 || mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL br_target: pc=%h req=%b addr=%h want 0000 1 0000", pc, mem_req, mem_addr);
        end
        wait_exec(16'hFFFF, hold);
        pc_load = 1'b1; pc_load_val = 16'h1234;
        @(negedge clk);
        pc_load = 1'b0;
        checks++;
        if (pc !== 16'h1234 || mem_addr !== 16'h1234) begin
            failures++;
            $display("FAIL br_pcload: pc=%h addr=%h want 1234 1234", pc, mem_addr);
        end
    endtask

    task automatic test_pc_wrap();
        int base, hold;
        apply_reset();
        mem[0] = 8'hC7; mem[1] = 8'hFD;
        release_reset(base);
        wait_exec(16'hFFFF, hold);
        @(negedge clk);
        checks++;
        if (pc !== 16'hFFFF || mem_addr !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_target: pc=%h addr=%h want FFFF FFFF", pc, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (pc !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_inc: pc=%h want 0000", pc);
        end
    endtask

    task automatic test_halt();
        int base, hold, bad;
        apply_reset();
        mem[0] = 8'h01;
        release_reset(base);
        wait_exec(16'hFFFF, hold);
        // resume outside HALTED must have no effect
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        checks++;
        if (halted !== 1'b1 || mem_req !== 1'b0 || dec_en !== 1'b0 || pc !== 16'h0001) begin
            failures++;
            $display("FAIL halt_enter: halted=%b req=%b en=%b pc=%h want 1 0 0 0001",
                     halted, mem_req, dec_en, pc);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_hold: bad cycles=%0d want 0", bad);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        checks++;
        if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0001) begin
            failures++;
            $display("FAIL halt_resume: halted=%b req=%b addr=%h want 0 1 0001", halted, mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit hit = 1'b0;
        apply_reset();
        mem[0] = 8'h84; mem[1] = 8'h10;
        dp = 16'h0100; ack_delay = 4'd3;
        release_reset(base);
        for (int i = 0; i < 60; i++) begin
            if (!hit) begin
                @(negedge clk);
                if (mem_req && mem_addr == 16'h0110) hit = 1'b1;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rmid_reach: operand read at 0110 not seen");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 16'h0000 || dec_en !== 1'b0) begin
            failures++;
            $display("FAIL rmid_drop: req=%b pc=%h en=%b want 0 0000 0", mem_req, pc, dec_en);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nop();
        test_two_byte();
        test_imm();
        test_ram_wait();
        test_indirect();
        test_store_wrap();
        test_branch();
        test_pc_wrap();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit CPU. It drives the instruction decoder and sequences each instruction over a byte-wide memory bus.
- Per instruction, in order: opcode byte fetch, argument byte fetch, optional extended-data byte, optional RAM operand or indirect-pointer reads, store write, then a one-cycle execute strobe.
- Owns the program counter, branch target update, and halt/resume.
- Sits between the memory arbiter port and the decoder/ALU.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  bus request; address and write data held stable while high
- mem_we  out  1  write qualifier, valid with mem_req
- mem_addr  out  16  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid when mem_ack=1
- mem_ack  in  1  transfer complete; may be high in the same cycle as mem_req (zero-wait)
- dec_en  out  1  decoder enable
- inst  out  16  instruction register to decoder; [15:8] opcode byte, [7:0] argument byte
- data  out  8  extended immediate byte to decoder
- operand  out  8  byte read from RAM for source_ram/source_indirect
- dec_bytes  in  2  decoder instruction length (1 or 2)
- dec_source_imm, dec_source_ram, dec_source_indirect, dec_relative_stack  in  1 each  decoder source flags
- dec_store, dec_branch, dec_halt  in  1 each  decoder opcode flags
- dec_rhs  in  16  decoder rhs; branch offset for branch
- dp, sp  in  16 each  data/stack base pointers
- store_data  in  8  byte to write for store (accumulator low byte)
- pc_load  in  1  execute unit overrides PC (call/return/if); sampled only in EXEC
- pc_load_val  in  16  override value
- resume  in  1  leave HALTED
- pc  out  16  address of the next byte to fetch
- exec_strobe  out  1  one-cycle pulse; decoder outputs, data and operand valid
- halted  out  1  high in HALTED

Behaviour:
- Reset (async, immediate):
  - state=FETCH0, pc=RESET_PC.
  - inst, data and operand are 0.
  - mem_req, mem_we, mem_wdata, dec_en, exec_strobe and halted are 0.
  - Reset mid-transfer drops mem_req in the same cycle; the pending access is abandoned.
- Bus rule: a transfer completes on a rising edge with mem_req=1 and mem_ack=1. The state holds otherwise. Each completed instruction-stream read increments pc by 1 (16-bit wrap, FFFF→0000).
- dec_en=1 in every state except FETCH0 and HALTED.
- States:
  - FETCH0: read at pc. On ack: inst={rdata,8'h00}; if rdata[7]=0 go EXEC_CHK, else FETCH1.
  - FETCH1: read at pc. On ack: inst[7:0]=rdata; go DATA if dec_source_imm=1 and inst[9]=1, else ADDR.
    - Note: dec_* reflect inst only from the cycle after it loads; ADDR/EXEC_CHK exist for this.
  - DATA: read at pc. On ack: data=rdata; go EXEC.
  - ADDR (1 cycle, no bus):
    - ea = (dec_relative_stack ? sp : dp) + {8'h00, inst[7:0]}.
    - dec_source_indirect → PTR_LO.
    - dec_source_ram and dec_store → WRITE.
    - dec_source_ram → OPER.
    - otherwise → EXEC.
  - PTR_LO: read ea, capture low byte of pointer.
  - PTR_HI: read ea+1; ea={rdata, low}. Then → WRITE if dec_store, else OPER.
  - OPER: read ea; operand=rdata; → EXEC.
  - WRITE: mem_we=1, mem_addr=ea, mem_wdata=store_data; on ack → EXEC.
  - EXEC_CHK (1 cycle, no bus): → EXEC. Gives one-byte opcodes a settled decode.
  - EXEC (1 cycle): exec_strobe=1. PC update priority:
    - pc_load → pc=pc_load_val.
    - else dec_branch → pc=pc+dec_rhs (relative to the byte after the instruction).
    - else unchanged.
  - After EXEC: dec_halt → HALTED, else FETCH0.
  - HALTED: no bus activity, halted=1; resume → FETCH0 with pc unchanged. resume is ignored in all other states.
- ea arithmetic is 16-bit modulo; ea+1 wraps.
- mem_we is 0 in all states except WRITE.

Decomposition:
- Shared package cpu_pkg:
  - state enum, 4-bit encoding.
  - opcode byte constants (NOP 8'h00, HALT 8'h01, LOAD_IND 8'h44).
  - mask constants for one-arg class (16'hF800) and source field (16'h0700).
- Sub-module: bus_port. Holds mem_req/addr/we/wdata stable, produces a done pulse and the registered read byte.
- The FSM and PC live in fetch_sequencer.

Test Plan:
- Reset, memory {00} at 0, zero-wait ack → mem_addr=0000 read, exec_strobe 2 cycles later, next fetch at 0001, pc=0001.
- Bytes {80,2A} → reads 0000, 0001; inst=802A; exec_strobe; pc=0002; no DATA/OPER cycle.
- Bytes {82,00,55} → three reads; data=55 at exec_strobe; pc=0003.
- Bytes {84,10}, dp=0100, RAM[0110]=77, ack delayed 3 cycles per transfer → mem_addr held 0110 with mem_req=1 for 4 cycles; operand=77.
- Bytes {C7,FE} (rhs=FFFE) → after EXEC pc=0000, refetch at 0000; with pc_load=1, pc_load_val=1234 in EXEC → pc=1234.
- Byte {01} → halted=1, mem_req=0 for 10 cycles; resume pulse → fetch at 0001. Assert rst during OPER → mem_req=0 and pc=RESET_PC immediately.
